// File: rtl/sbox_pkg.sv
// Shared constants for the iterative S-box layer: box width, lookup tables and FSM states.
// The inverse table exists only when SBOX_INVERSE_EN is defined.
package sbox_pkg;

  localparam int unsigned SBOX_W = 5;

  typedef logic [SBOX_W-1:0] box_t;

  // Index is the 5-bit box value: row = bit 4, column = bits 3:0.
  localparam box_t SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

`ifdef SBOX_INVERSE_EN
  // INV_SBOX[SBOX[x]] == x for every x.
  localparam box_t INV_SBOX [32] = '{
    5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
    5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
    5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
    5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
  };
`endif

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/sbox_lane.sv
// Combinational single-box lookup. Under SBOX_INVERSE_EN an inv_i select picks the
// inverse table instead of the forward one.
module sbox_lane
  import sbox_pkg::*;
(
  input  logic [SBOX_W-1:0] box_i,
`ifdef SBOX_INVERSE_EN
  input  logic              inv_i,
`endif
  output logic [SBOX_W-1:0] box_o
);

  always_comb begin
    box_o = SBOX[box_i];
`ifdef SBOX_INVERSE_EN
    if (inv_i) begin
      box_o = INV_SBOX[box_i];
    end
`endif
  end

endmodule

// File: rtl/sbox_layer_seq.sv
// Iterative S-box layer: NBOX 5-bit boxes substituted LANES per clock under valid/ready.
// Optional SBOX_INVERSE_EN adds the in_inv port and inverse-table lanes.
module sbox_layer_seq
  import sbox_pkg::*;
#(
  parameter int unsigned NBOX  = 8,
  parameter int unsigned LANES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SBOX_W*NBOX-1:0] in_data,
`ifdef SBOX_INVERSE_EN
  input  logic                   in_inv,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SBOX_W*NBOX-1:0] out_data,
  output logic                   busy
);

  localparam int unsigned STEPS   = (LANES == 0) ? 1 : NBOX / LANES;
  localparam int unsigned CNT_W   = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned WORD_W  = SBOX_W * NBOX;
  localparam int unsigned SLICE_W = SBOX_W * LANES;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  if (NBOX < 1 || LANES < 1 || (NBOX % LANES) != 0) begin : g_bad_cfg
    $error("sbox_layer_seq: LANES must be >= 1 and divide NBOX (>= 1)");
  end

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  work_q, work_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic [SLICE_W-1:0] sub_slice;
  logic [WORD_W-1:0]  rotated;
`ifdef SBOX_INVERSE_EN
  logic               inv_q, inv_d;
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sbox_lane u_lane (
      .box_i (work_q[SBOX_W*l +: SBOX_W]),
`ifdef SBOX_INVERSE_EN
      .inv_i (inv_q),
`endif
      .box_o (sub_slice[SBOX_W*l +: SBOX_W])
    );
  end

  // Rotate right by one slice and put the substituted low slice on top; after
  // STEPS rotations every box is back at its original position.
  if (STEPS == 1) begin : g_rot_full
    assign rotated = sub_slice;
  end else begin : g_rot
    assign rotated = {sub_slice, work_q[WORD_W-1:SLICE_W]};
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
`ifdef SBOX_INVERSE_EN
    inv_d    = inv_q;
`endif
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = in_data;
          cnt_d   = '0;
          state_d = RUN;
`ifdef SBOX_INVERSE_EN
          inv_d   = in_inv;
`endif
        end
      end
      RUN: begin
        work_d = rotated;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            work_d  = in_data;
            cnt_d   = '0;
            state_d = RUN;
`ifdef SBOX_INVERSE_EN
            inv_d   = in_inv;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      work_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SBOX_INVERSE_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef SBOX_INVERSE_EN
      inv_q       <= inv_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = work_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sbox_layer_seq.sv
// Scoreboard bench for sbox_layer_seq: main (8,2) instance plus (8,8), (8,1), (1,1) sweep.
// Exercises the inverse path when SBOX_INVERSE_EN is defined.
module tb_sbox_layer_seq;

  localparam logic [4:0] REF [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [4:0] inv_box(input logic [4:0] y);
    inv_box = '0;
    for (int x = 0; x < 32; x++) begin
      if (REF[x] == y) inv_box = 5'(x);
    end
  endfunction

  function automatic logic [39:0] model(input logic [39:0] d, input int nbox, input logic inv);
    logic [4:0] b;
    model = '0;
    for (int i = 0; i < nbox; i++) begin
      b = d[5*i +: 5];
      model[5*i +: 5] = inv ? inv_box(b) : REF[b];
    end
  endfunction

  // ---------------- main instance (NBOX=8, LANES=2) ----------------
  logic        rst = 1'b1;
  logic        sw_rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [39:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [39:0] out_data;
  logic        busy;
  logic        acc_inv;
`ifdef SBOX_INVERSE_EN
  logic        in_inv = 1'b0;
  assign acc_inv = in_inv;
`else
  assign acc_inv = 1'b0;
`endif

  sbox_layer_seq #(.NBOX(8), .LANES(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef SBOX_INVERSE_EN
    .in_inv    (in_inv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  logic [39:0] exp_q [$];
  int unsigned acc_q [$];
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data, 8, acc_inv));
        acc_q.push_back(cyc + 1);
      end
      if (prev_valid && !prev_ready) chk("hold_valid", 40'(out_valid), 40'd1);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 40'(out_valid), 40'd0);
        end else begin
          if (!prev_valid) chk("latency", 40'(cyc - acc_q[0]), 40'd4);
          chk("data", out_data, exp_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
    end
  end

  task automatic send(input logic [39:0] w, input logic inv);
    int unsigned n;
    n = 0;
    in_data = w;
`ifdef SBOX_INVERSE_EN
    in_inv = inv;
`else
    if (inv) $display("note: inverse request ignored in forward-only build");
`endif
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", 40'(in_ready), 40'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 40'(exp_q.size()), 40'd0);
    @(posedge clk); #1;
  endtask

  function automatic logic [39:0] rand_word();
    rand_word = '0;
    for (int b = 0; b < 8; b++) rand_word[5*b +: 5] = 5'($urandom_range(0, 31));
  endfunction

  // ---------------- parameter sweep instances ----------------
  bit sw_done [3];

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int NB  = (g == 2) ? 1 : 8;
    localparam int LN  = (g == 0) ? 8 : 1;
    localparam int LAT = (g == 1) ? 8 : 1;

    logic            s_in_valid = 1'b0;
    logic            s_in_ready;
    logic [5*NB-1:0] s_in_data = '0;
    logic            s_out_valid;
    logic [5*NB-1:0] s_out_data;
    logic            s_busy;
    logic [39:0]     sq [$];
    int unsigned     sa [$];
    logic            s_prev_valid = 1'b0;

    sbox_layer_seq #(.NBOX(NB), .LANES(LN)) u_sw (
      .clk       (clk),
      .rst       (sw_rst),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .in_data   (s_in_data),
`ifdef SBOX_INVERSE_EN
      .in_inv    (1'b0),
`endif
      .out_valid (s_out_valid),
      .out_ready (1'b1),
      .out_data  (s_out_data),
      .busy      (s_busy)
    );

    always @(negedge clk) begin
      if (!sw_rst) begin
        if (s_in_valid && s_in_ready) begin
          sq.push_back(model(40'(s_in_data), NB, 1'b0));
          sa.push_back(cyc + 1);
        end
        if (s_out_valid) begin
          if (sq.size() == 0) begin
            chk($sformatf("sweep%0d_unexpected", g), 40'(s_out_valid), 40'd0);
          end else begin
            if (!s_prev_valid) chk($sformatf("sweep%0d_latency", g), 40'(cyc - sa[0]), 40'(LAT));
            chk($sformatf("sweep%0d_data", g), 40'(s_out_data), sq[0]);
            void'(sq.pop_front());
            void'(sa.pop_front());
          end
        end
        s_prev_valid = s_out_valid;
      end
    end

    initial begin
      int unsigned n;
      @(negedge sw_rst);
      for (int k = 0; k < 12; k++) begin
        @(posedge clk); #1;
        for (int b = 0; b < NB; b++) s_in_data[5*b +: 5] = 5'($urandom_range(0, 31));
        s_in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_in_ready && n < 100) begin
          @(negedge clk);
          n++;
        end
        chk($sformatf("sweep%0d_accept", g), 40'(s_in_ready), 40'd1);
        @(posedge clk); #1;
        s_in_valid = 1'b0;
      end
      n = 0;
      while (sq.size() != 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("sweep%0d_drain", g), 40'(sq.size()), 40'd0);
      sw_done[g] = 1'b1;
    end
  end

  // ---------------- main stimulus ----------------
  initial begin
    logic [39:0] w;
    logic [39:0] w2;
    int unsigned n;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 40'(in_ready), 40'd1);
    chk("rst_out_valid", 40'(out_valid), 40'd0);
    chk("rst_out_data", out_data, 40'd0);
    chk("rst_busy", 40'(busy), 40'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    sw_rst = 1'b0;

    // every value replicated into all boxes
    for (int v = 0; v < 32; v++) begin
      for (int b = 0; b < 8; b++) w[5*b +: 5] = 5'(v);
      send(w, 1'b0);
    end

    // box i holds value i: detects rotation or ordering errors
    for (int b = 0; b < 8; b++) w[5*b +: 5] = 5'(b);
    send(w, 1'b0);

    // random words with random consumer stalls
    for (int k = 0; k < 20; k++) begin
      send(rand_word(), 1'b0);
      out_ready = 1'b0;
      repeat ($urandom_range(0, 6)) begin
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
    end
    drain();

    // back-pressure then simultaneous handshakes
    w  = rand_word();
    w2 = rand_word();
    out_ready = 1'b0;
    send(w, 1'b0);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid", 40'(out_valid), 40'd1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_data", out_data, model(w, 8, 1'b0));
      chk("bp_in_ready", 40'(in_ready), 40'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = w2;
    @(negedge clk);
    chk("b2b_in_ready", 40'(in_ready), 40'd1);
    chk("b2b_out_valid", 40'(out_valid), 40'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_busy", 40'(busy), 40'd1);
    chk("b2b_out_valid_drop", 40'(out_valid), 40'd0);
    drain();

    // reset two cycles after acceptance, then reset racing a valid input
    send(rand_word(), 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = rand_word();
    @(negedge clk);
    chk("midrst_busy", 40'(busy), 40'd0);
    chk("midrst_out_valid", 40'(out_valid), 40'd0);
    chk("midrst_out_data", out_data, 40'd0);
    chk("midrst_in_ready", 40'(in_ready), 40'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_prio_busy", 40'(busy), 40'd0);
    chk("rst_prio_out_valid", 40'(out_valid), 40'd0);
    repeat (12) @(posedge clk);
    #1;

`ifdef SBOX_INVERSE_EN
    // forward then inverse must give back the original; in_inv toggles mid-run
    for (int k = 0; k < 8; k++) begin
      w = rand_word();
      send(w, 1'b0);
      repeat (3) begin
        in_inv = ~in_inv;
        @(posedge clk); #1;
      end
      drain();
      send(model(w, 8, 1'b0), 1'b1);
      repeat (3) begin
        in_inv = ~in_inv;
        @(posedge clk); #1;
      end
      drain();
      chk("inv_roundtrip_model", model(model(w, 8, 1'b0), 8, 1'b1), w);
    end
`endif

    drain();
    n = 0;
    while (!(sw_done[0] && sw_done[1] && sw_done[2]) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("sweep_finished", 40'(sw_done[0] && sw_done[1] && sw_done[2]), 40'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sbox_layer_seq.md
# sbox_layer_seq

Parametrised, iterative successor to the single 5-bit S-box layer: substitutes a wide word of NBOX independent 5-bit boxes using LANES S-box instances per clock, under a valid/ready handshake on both sides. It sits between the round-key mixing stage and the permutation layer of the cipher datapath. It trades area against latency: LANES = NBOX gives a one-step layer; LANES = 1 gives a fully serial layer.

## Interface
- NBOX, default 8: number of 5-bit boxes in the word. Must be ≥ 1.
- LANES, default 2: boxes substituted per clock. Must be ≥ 1 and must divide NBOX; any other value is an elaboration error.
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  input word is presented.
- in_ready  out  1  block accepts a word at this edge.
- in_data  in  5*NBOX  box i occupies bits [5i+4:5i].
- in_inv  in  1  present only with SBOX_INVERSE_EN. 1 selects the inverse table.
- out_valid  out  1  out_data holds a finished result.
- out_ready  in  1  consumer takes the result at this edge.
- out_data  out  5*NBOX  substituted word, same box layout as in_data.
- busy  out  1  state is not IDLE.

## Operation
- The per-box mapping is the team's 32-entry S-box table. The index is the 5-bit box value: row = bit 4, column = bits 3:0.
- Each box is substituted independently. There is no carry or mixing between boxes.
- STEPS = NBOX/LANES. The step counter is $clog2(STEPS) bits wide, with a minimum of 1.
- FSM states and transitions:
  - IDLE: in_ready = 1. On in_valid, load in_data into the work register, latch in_inv, clear the step counter, and go to RUN.
  - RUN: each edge substitutes the LANES lowest boxes of the work register. The register is rotated right by 5*LANES bits, and the substituted slice is inserted at the top. The counter increments. After STEPS edges the word is back in its original box order; go to DONE.
  - DONE: out_valid = 1 and out_data = the work register, both held stable until out_ready.
    - out_ready with no in_valid: go to IDLE.
    - out_ready with in_valid: complete both handshakes on the same edge, load the new word, and go to RUN.
- Combinational ready: in_ready = (state == IDLE) | (state == DONE & out_ready).
- in_data and in_inv are sampled only at the acceptance edge. Changes during RUN have no effect.
- out_data is registered and does not change while out_valid = 1 and out_ready = 0.
- Reset values: state IDLE, work register 0, counter 0, out_valid 0, out_data 0, busy 0, in_ready 1 (follows from IDLE).
- Reset mid-operation (RUN or DONE): the word in flight is discarded with no output handshake. The block is in IDLE on the next cycle.
- If rst and in_valid are high on the same edge, reset wins and no word is accepted.

## Timing
- Latency: out_valid rises exactly STEPS cycles after the acceptance edge.
- Throughput with out_ready held high: one word per STEPS+1 cycles.
- in_ready has a combinational path from out_ready and from state only. It does not depend on in_valid.
- All other outputs are driven directly from registers.

## Configuration
- SBOX_INVERSE_EN defined:
  - in_inv port exists.
  - An inverse table (INV_SBOX, with INV_SBOX[SBOX[x]] = x) is compiled in.
  - Each lane muxes between the forward and inverse tables using the latched in_inv.
- SBOX_INVERSE_EN undefined:
  - in_inv port is absent and the inverse table is not built.
  - The block is forward-only; all other behaviour is identical.

## Structure
- Package sbox_pkg contains:
  - SBOX_W = 5.
  - The forward SBOX table, as a constant array of 32 entries.
  - INV_SBOX, guarded by the macro.
  - The FSM state enum: IDLE, RUN, DONE.
- One sub-module, sbox_lane: a combinational single-box lookup (5-bit in, 5-bit out, plus an inv select under the macro). It is instantiated LANES times in a generate loop.
- The top holds the FSM, the counter, the rotating work register and the handshake logic.

## Test plan
- Exhaustive: NBOX=8, LANES=2. Drive each value 0..31 replicated into all 8 boxes. Each result must equal SBOX[v] in every box, out_valid must rise 4 cycles after acceptance, and out_data must match the reference model.
- Box order: NBOX=8, LANES=2, in_data with box i = i (0x0..0x7 in 5-bit fields). Box i of out_data must equal SBOX[i]; any rotation or order error fails this.
- Back-pressure and back-to-back: hold out_ready=0 for 5 cycles in DONE, checking that out_data is stable and in_ready=0. Then raise out_ready with in_valid=1: both handshakes must occur on one edge, and the next out_valid must come 4 cycles later.
- Reset mid-RUN: assert rst 2 cycles after acceptance. Next cycle: state IDLE, out_valid=0, out_data=0, busy=0, and no output handshake ever occurs for the dropped word.
- Parameter sweep: (NBOX,LANES) = (8,8), (8,1) and (1,1). Latency must be 1, 8 and 1 cycles respectively, and results must match the reference model for random inputs.
- With SBOX_INVERSE_EN: a forward pass then an inverse pass of random words must return the original word. Toggling in_inv during RUN must not affect the word in flight.
